// File: rtl/lfsr_rng_stream.sv
// ----------------------------------------------------------------------------
// lfsr_rng_stream
//
// Pseudo-random sample source with a ready/valid output stream.
// A single Galois LFSR (right-shifting) supplies candidates. In bounded-range
// mode, each candidate is the low WIDTH bits of the LFSR masked down to the
// bit length of range_max. Candidates above range_max are rejected. Because
// the mask never exceeds twice the bound, accepted values are uniform over
// 0..range_max, and fewer than half of all candidates are rejected.
//
// Parameters
//   LFSR_W : LFSR state width (4..32)
//   WIDTH  : output sample width, WIDTH <= LFSR_W
//   TAPS   : Galois feedback mask, LFSR_W bits
//   SEED   : reset and zero-recovery seed, LFSR_W bits, nonzero
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   advance the LFSR and allow sample capture
//   seed_load  in   load seed_in into the LFSR (seed 0 maps to SEED); beats en
//   seed_in    in   runtime seed value
//   range_max  in   inclusive upper bound of delivered samples
//   out_valid  out  out_data holds an unconsumed sample
//   out_ready  in   consumer accepts the sample this cycle
//   out_data   out  random sample in 0..range_max
//   rej_cnt    out  saturating count of rejected candidates
// ----------------------------------------------------------------------------
module lfsr_rng_stream #(
    parameter int unsigned        LFSR_W = 16,
    parameter int unsigned        WIDTH  = 10,
    parameter logic [LFSR_W-1:0]  TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [WIDTH-1:0]  range_max,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [15:0]       rej_cnt
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0]  r_out_data;
    logic [WIDTH-1:0]  w_out_data_nxt;
    logic [15:0]       r_rej_cnt;
    logic              w_rej_inc;

    logic [WIDTH-1:0]  w_mask;
    logic [WIDTH-1:0]  w_cand;
    logic              w_step;
    logic              w_fits;
    logic              w_accept;
    logic              w_reject;
    logic              w_handshake;

    // ------------------------------------------------------------------
    // LFSR next state: seed load wins. A zero state is recovered by
    // reloading SEED. Otherwise, step while enabled.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assign every always_comb output a default first, so that no
        // path through the block leaves it unassigned and infers a latch.
        w_lfsr_nxt = r_lfsr;
        if (seed_load) begin
            w_lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        end else if (r_lfsr == '0) begin
            w_lfsr_nxt = SEED;
        end else if (en) begin
            w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    // ------------------------------------------------------------------
    // Mask: ones from bit 0 up to the highest set bit of range_max.
    // Bit i is set when any bit at or above i in range_max is set.
    // ------------------------------------------------------------------
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = |(range_max >> i);
        end
    end

    assign w_cand      = r_lfsr[WIDTH-1:0] & w_mask;
    assign w_step      = en & ~seed_load;
    assign w_fits      = (w_cand <= range_max);
    assign w_accept    = w_step & w_fits;
    assign w_reject    = w_step & ~w_fits;
    assign w_handshake = (r_state == ST_HOLD) & out_ready;

    // ------------------------------------------------------------------
    // Output FSM: FILL searches for an acceptable candidate.
    // HOLD presents the sample until the consumer takes it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_out_data_nxt = r_out_data;
        w_rej_inc      = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    w_out_data_nxt = w_cand;
                    w_state_nxt    = ST_HOLD;
                end else if (w_reject) begin
                    w_rej_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                // Rejections are only counted when the slot is free again.
                // While backpressured, candidates are not evaluated.
                if (w_handshake) begin
                    if (w_accept) begin
                        w_out_data_nxt = w_cand;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_rej_inc   = w_reject;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_lfsr     <= SEED;
            r_out_data <= '0;
            r_rej_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // values from before the edge, regardless of statement order.
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_out_data <= w_out_data_nxt;
            if (w_rej_inc && (r_rej_cnt != 16'hFFFF)) begin
                r_rej_cnt <= r_rej_cnt + 16'd1;
            end
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign rej_cnt   = r_rej_cnt;

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng_stream
//
// Scoreboard bench for lfsr_rng_stream, using the default parameters.
// The stimulus pushes hand-computed expected samples into a queue.
// A monitor pops one entry per output handshake at the falling edge and
// compares it with out_data. The stimulus also checks state directly.
// LFSR sequence from ACE1: ACE1 E270 7138 389C 1C4E 0E27 B313 ED89 ...
// ----------------------------------------------------------------------------
module tb_lfsr_rng_stream;

    localparam int W = 10;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         seed_load = 1'b0;
    logic [L-1:0] seed_in = '0;
    logic [W-1:0] range_max = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [15:0]  rej_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] sb_q[$];

    lfsr_rng_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .range_max (range_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rej_cnt   (rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset is held across one rising edge and released on a falling edge.
    task automatic do_reset(input logic [W-1:0] rng, input logic e, input logic rdy);
        @(negedge clk);
        rst_n     = 1'b0;
        range_max = rng;
        en        = e;
        out_ready = rdy;
        seed_load = 1'b0;
        seed_in   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted handshake consumes one expected sample.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got 0x%0h, expected no sample", out_data);
                end else begin
                    check("sample", 32'(out_data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: full range, streaming back to back
        do_reset(10'd1023, 1'b1, 1'b1);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rej", 32'(rej_cnt), 32'd0);
        sb_q.push_back(10'h0E1);
        sb_q.push_back(10'h270);
        sb_q.push_back(10'h138);
        sb_q.push_back(10'h09C);
        repeat (4) begin
            tick();
            check("p1_valid", 32'(out_valid), 32'd1);
        end
        en = 1'b0;
        tick();
        check("p1_valid_drop", 32'(out_valid), 32'd0);
        check("p1_rej", 32'(rej_cnt), 32'd0);
        check("p1_sb_empty", 32'(sb_q.size()), 32'd0);

        // 2: range 70, so 97 and 112 are rejected and 56 is accepted
        do_reset(10'd70, 1'b1, 1'b1);
        sb_q.push_back(10'd56);
        tick();
        check("p2_valid_e1", 32'(out_valid), 32'd0);
        check("p2_rej_e1", 32'(rej_cnt), 32'd1);
        tick();
        check("p2_valid_e2", 32'(out_valid), 32'd0);
        check("p2_rej_e2", 32'(rej_cnt), 32'd2);
        tick();
        check("p2_valid_e3", 32'(out_valid), 32'd1);
        check("p2_data_e3", 32'(out_data), 32'd56);
        en = 1'b0;
        tick();
        check("p2_rej_final", 32'(rej_cnt), 32'd2);
        check("p2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3: backpressure for 5 cycles while the LFSR keeps stepping
        do_reset(10'd1023, 1'b1, 1'b0);
        sb_q.push_back(10'h0E1);
        sb_q.push_back(10'h313);
        tick();
        check("p3_first", 32'(out_data), 32'h0E1);
        repeat (5) begin
            tick();
            check("p3_hold_valid", 32'(out_valid), 32'd1);
            check("p3_hold_data", 32'(out_data), 32'h0E1);
        end
        out_ready = 1'b1;
        tick();
        check("p3_after_bp", 32'(out_data), 32'h313);
        en = 1'b0;
        tick();
        check("p3_sb_empty", 32'(sb_q.size()), 32'd0);

        // 4: seed loads, with the held sample untouched
        do_reset(10'd1023, 1'b1, 1'b0);
        sb_q.push_back(10'h0E1);
        tick();
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        check("p4_seed0_valid", 32'(out_valid), 32'd1);
        check("p4_seed0_data", 32'(out_data), 32'h0E1);
        seed_load = 1'b0;
        en        = 1'b0;
        out_ready = 1'b1;
        tick();
        check("p4_drain_en0", 32'(out_valid), 32'd0);
        sb_q.push_back(10'h0E1);
        en        = 1'b1;
        out_ready = 1'b0;
        tick();
        check("p4_reseed_data", 32'(out_data), 32'h0E1);
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        tick();
        check("p4_seed1234_valid", 32'(out_valid), 32'd1);
        check("p4_seed1234_data", 32'(out_data), 32'h0E1);
        sb_q.push_back(10'h234);
        sb_q.push_back(10'h11A);
        seed_load = 1'b0;
        out_ready = 1'b1;
        tick();
        check("p4_from1234", 32'(out_data), 32'h234);
        tick();
        check("p4_from091A", 32'(out_data), 32'h11A);
        en = 1'b0;
        tick();
        check("p4_sb_empty", 32'(sb_q.size()), 32'd0);

        // 5: en low in FILL freezes everything
        do_reset(10'd70, 1'b1, 1'b1);
        sb_q.push_back(10'd56);
        tick();
        check("p5_rej_e1", 32'(rej_cnt), 32'd1);
        en = 1'b0;
        repeat (4) begin
            tick();
            check("p5_frozen_rej", 32'(rej_cnt), 32'd1);
            check("p5_frozen_valid", 32'(out_valid), 32'd0);
        end
        en = 1'b1;
        tick();
        check("p5_rej_resume", 32'(rej_cnt), 32'd2);
        check("p5_valid_resume", 32'(out_valid), 32'd0);
        tick();
        check("p5_data", 32'(out_data), 32'd56);
        en = 1'b0;
        tick();
        check("p5_sb_empty", 32'(sb_q.size()), 32'd0);

        // 6: range_max 0, so every sample is 0 and nothing is rejected
        do_reset(10'd0, 1'b1, 1'b1);
        repeat (4) sb_q.push_back(10'd0);
        repeat (4) begin
            tick();
            check("p6_valid", 32'(out_valid), 32'd1);
        end
        en = 1'b0;
        tick();
        check("p6_rej", 32'(rej_cnt), 32'd0);
        check("p6_sb_empty", 32'(sb_q.size()), 32'd0);

        // 7: asynchronous reset while a sample is held
        do_reset(10'd70, 1'b1, 1'b0);
        repeat (3) tick();
        check("p7_pre_valid", 32'(out_valid), 32'd1);
        check("p7_pre_data", 32'(out_data), 32'd56);
        check("p7_pre_rej", 32'(rej_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("p7_async_valid", 32'(out_valid), 32'd0);
        check("p7_async_data", 32'(out_data), 32'd0);
        check("p7_async_rej", 32'(rej_cnt), 32'd0);
        do_reset(10'd1023, 1'b1, 1'b1);
        sb_q.push_back(10'h0E1);
        sb_q.push_back(10'h270);
        tick();
        tick();
        en = 1'b0;
        tick();
        check("p7_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_stream.md
Name: lfsr_rng_stream

Overview:
- Parametrised pseudo-random number source with a ready/valid output stream. It succeeds the fixed two-5-bit-LFSR generator.
- A single Galois LFSR of configurable width and polynomial supplies candidates. A runtime-loadable seed replaces the fixed reset pattern.
- A bounded-range mode uses mask-and-reject sampling, so consumers get uniformly distributed values in 0..range_max.
- Sits between the game/control logic and any block needing random values.

Parameters:
- LFSR_W, 16, LFSR state width (4..32).
- WIDTH, 10, output sample width; must satisfy WIDTH <= LFSR_W.
- TAPS, 16'hB400, Galois feedback polynomial mask, LFSR_W bits.
- SEED, 16'hACE1, reset and zero-recovery seed, LFSR_W bits, nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance LFSR / allow sample capture.
- seed_load  in  1  load seed_in into LFSR this cycle.
- seed_in  in  LFSR_W  seed value.
- range_max  in  WIDTH  inclusive upper bound of output values.
- out_valid  out  1  out_data holds an unconsumed sample.
- out_ready  in  1  consumer accepts sample.
- out_data  out  WIDTH  random sample, 0..range_max.
- rej_cnt  out  16  saturating count of rejected candidates.

Behaviour:
- Reset (async, rst_n=0):
  - lfsr=SEED, out_valid=0, out_data=0, rej_cnt=0, FSM=FILL.
  - Reset asserted mid-operation discards any held sample immediately.
- LFSR step, Galois right-shift: next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
  - Steps once per clk when en=1 and seed_load=0.
  - Frozen when en=0.
- seed_load has priority over en.
  - lfsr <= (seed_in==0) ? SEED : seed_in.
  - No step that cycle; FSM, out_valid, out_data unaffected.
- Zero-lockup guard: if lfsr==0 is ever observed, the next edge loads SEED instead of stepping.
- Mask:
  - mask = all ones from bit 0 through the MSB set in range_max.
  - range_max==0 gives mask=0.
- Candidate:
  - cand = lfsr[WIDTH-1:0] & mask, using the current (pre-step) lfsr.
  - acceptable when en=1, seed_load=0 and cand <= range_max.
- FSM has two states: FILL and HOLD.
  - FILL, out_valid=0:
    - If acceptable: out_data<=cand, out_valid<=1, go HOLD.
    - Else if en=1, seed_load=0: rejected; rej_cnt increments, saturating at 16'hFFFF.
    - Else hold.
  - HOLD, out_valid=1: out_data stable until handshake (out_valid & out_ready).
    - On handshake with acceptable cand: load cand, stay HOLD. Back-to-back throughput is 1 sample/cycle.
    - On handshake with cand rejected (en=1, seed_load=0): out_valid<=0, rej_cnt++, go FILL.
    - On handshake with en=0 or seed_load=1: out_valid<=0, go FILL.
    - No handshake: hold out_data/out_valid; LFSR keeps stepping if en=1; no rejection counting.
  - out_valid never deasserts without a handshake or reset, including when en drops.
- Latency: an accepted candidate appears on out_data/out_valid 1 clk after the cycle it is evaluated.
- range_max is sampled combinationally each cycle. A change affects only future captures; the held out_data is not revalidated.
- range_max == all ones: no rejections possible.
- range_max == 0: every candidate is 0 and is accepted.
- Rejection probability per candidate is < 1/2 by construction; no retry limit.

Test Plan:
- Defaults, range_max=1023, out_ready=1, en=1 after reset → out_data sequence 0x0E1, 0x270, 0x138, 0x09C on consecutive cycles (lfsr ACE1, E270, 7138, 389C), out_valid held 1, rej_cnt=0.
- range_max=70 (mask 0x7F), en=1 from reset → candidates 97 and 112 rejected; out_valid rises on 3rd edge with out_data=56; rej_cnt=2.
- Backpressure: first sample 0x0E1 captured, out_ready=0 for 5 cycles → out_data stays 0x0E1 with out_valid=1, lfsr keeps stepping; on first out_ready=1 the next out_data equals current-lfsr & 0x3FF.
- seed_load=1 with seed_in=0 → lfsr=0xACE1; with seed_in=0x1234 → lfsr=0x1234, and the next edge with en=1 gives 0x091A. The held out_valid/out_data is unchanged in both cases.
- en=0 for 4 cycles in FILL → lfsr, rej_cnt, out_valid unchanged; range_max=0 → every delivered sample is 0, rej_cnt stays 0.
- Assert rst_n=0 while out_valid=1 → out_valid=0, out_data=0, rej_cnt=0 immediately (async); after release the sequence restarts at 0x0E1.
